// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, issues one memory request per instruction
// and hands the returned word to decode through a valid/ready handshake.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] nextPc,
    input  logic        pcWrite,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrOut,
    output logic        instrValid,
    input  logic        decodeReady,
    output logic        misaligned,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_TRAP} state_t;

    state_t state;
    logic   accept;

    assign accept   = instrValid & decodeReady;
    assign pcPlus4  = pcOut + 32'd4;
    assign imemAddr = pcOut;
    // Gated by reset so no request leaks out while reset is held across several edges.
    assign imemReq  = (state == S_REQ) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pcOut      <= RESET_PC;
            instrOut   <= '0;
            instrValid <= 1'b0;
            misaligned <= 1'b0;
            fetchCount <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imemReady) begin
                        instrOut   <= imemRdata;
                        instrValid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        instrValid <= 1'b0;
                        fetchCount <= fetchCount + 32'd1;
                        if (pcWrite && (nextPc[1:0] != 2'b00)) begin
                            misaligned <= 1'b1;
                            state      <= S_TRAP;
                        end else begin
                            if (pcWrite)
                                pcOut <= nextPc;
                            state <= S_REQ;
                        end
                    end
                end
                S_TRAP: ;
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetch addresses and instruction words are
// queued when stimulus is driven and compared when the handshakes occur.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, reset, pcWrite, imemReady, decodeReady;
    logic [31:0] nextPc, imemRdata;
    logic [31:0] pcOut, pcPlus4, imemAddr, instrOut, fetchCount;
    logic        imemReq, instrValid, misaligned;

    logic        use_p4;
    logic [31:0] npc_drv, junk;
    logic [31:0] aq[$];
    logic [31:0] iq[$];
    int          nchk, npass;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .nextPc(nextPc), .pcWrite(pcWrite),
        .pcOut(pcOut), .pcPlus4(pcPlus4), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemRdata(imemRdata), .instrOut(instrOut),
        .instrValid(instrValid), .decodeReady(decodeReady), .misaligned(misaligned),
        .fetchCount(fetchCount)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h0050_0093 + a;
    endfunction

    assign nextPc    = use_p4 ? pcPlus4 : npc_drv;
    assign imemRdata = memw(imemAddr) ^ junk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        aq.push_back(a);
        iq.push_back(memw(a));
    endtask

    task automatic do_reset();
        reset = 1'b1; imemReady = 1'b0; decodeReady = 1'b0; junk = '0;
        tick();
        tick();
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_pc", pcOut, RST_PC);
        chk("rst_cnt", fetchCount, 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_instr", instrOut, 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_req", 32'(imemReq), 32'd1);
        chk("rel_addr", imemAddr, RST_PC);
    endtask

    // Handshake monitor: pops the scoreboard whenever a transfer is about to happen.
    always @(negedge clk) begin
        if (!reset) begin
            if (imemReq && imemReady)
                chk("fetch_addr", imemAddr, (aq.size() != 0) ? aq.pop_front() : 32'hBAD0_0001);
            if (instrValid && decodeReady)
                chk("accept_instr", instrOut, (iq.size() != 0) ? iq.pop_front() : 32'hDEAD_DEAD);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nchk = 0; npass = 0;
        reset = 1'b1; pcWrite = 1'b0; imemReady = 1'b0; decodeReady = 1'b0;
        use_p4 = 1'b0; npc_drv = '0; junk = '0;

        // Sequential stream at full throughput
        do_reset();
        push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8);
        use_p4 = 1'b1; pcWrite = 1'b1; decodeReady = 1'b1; imemReady = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("alt_req", 32'(imemReq), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        imemReady = 1'b0; decodeReady = 1'b0;
        chk("seq_cnt", fetchCount, 32'd3);
        chk("seq_pc", pcOut, 32'hC);
        chk("seq_pc4", pcPlus4, 32'h10);

        // Memory stall in REQ
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", 32'(imemReq), 32'd1);
            chk("stall_addr", imemAddr, 32'h0);
            chk("stall_valid", 32'(instrValid), 32'd0);
        end

        // Decode stall in HOLD, then a branch; memory response is corrupted while ignored
        push_fetch(32'h0);
        imemReady = 1'b1;
        tick();
        junk = 32'h5A5A_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_instr", instrOut, memw(32'h0));
            chk("hold_valid", 32'(instrValid), 32'd1);
            chk("hold_pc", pcOut, 32'h0);
            chk("hold_cnt", fetchCount, 32'd0);
        end
        junk = '0; imemReady = 1'b0;
        use_p4 = 1'b0; npc_drv = 32'h40; pcWrite = 1'b1; decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chk("branch_addr", imemAddr, 32'h40);
        chk("branch_req", 32'(imemReq), 32'd1);
        chk("branch_cnt", fetchCount, 32'd1);

        // pcWrite=0 refetch, then jump to top of address space and wrap
        push_fetch(32'h40); push_fetch(32'h40); push_fetch(32'hFFFF_FFFC);
        imemReady = 1'b1; pcWrite = 1'b0; decodeReady = 1'b1;
        tick();
        tick();
        chk("refetch_addr", imemAddr, 32'h40);
        chk("refetch_pc", pcOut, 32'h40);
        tick();
        pcWrite = 1'b1; npc_drv = 32'hFFFF_FFFC;
        tick();
        chk("top_pc", pcOut, 32'hFFFF_FFFC);
        chk("top_pc4", pcPlus4, 32'h0);
        use_p4 = 1'b1;
        tick();
        tick();
        imemReady = 1'b0; decodeReady = 1'b0;
        chk("wrap_pc", pcOut, 32'h0);
        chk("wrap_cnt", fetchCount, 32'd4);

        // Misaligned target traps; only reset leaves TRAP
        push_fetch(32'h0);
        imemReady = 1'b1;
        tick();
        use_p4 = 1'b0; npc_drv = 32'h42; pcWrite = 1'b1; decodeReady = 1'b1;
        tick();
        chk("trap_mis", 32'(misaligned), 32'd1);
        chk("trap_req", 32'(imemReq), 32'd0);
        chk("trap_valid", 32'(instrValid), 32'd0);
        chk("trap_pc", pcOut, 32'h0);
        chk("trap_cnt", fetchCount, 32'd5);
        for (int i = 0; i < 3; i++) begin
            npc_drv = $urandom & 32'hFFFF_FFFC;
            imemReady = 1'b1; decodeReady = 1'b1;
            tick();
            chk("trap_stay_req", 32'(imemReq), 32'd0);
            chk("trap_stay_pc", pcOut, 32'h0);
            chk("trap_stay_cnt", fetchCount, 32'd5);
        end
        do_reset();

        // Reset during an accept in HOLD wins; the pending instruction is dropped
        aq.push_back(32'h0);
        imemReady = 1'b1;
        tick();
        imemReady = 1'b0; decodeReady = 1'b1; reset = 1'b1;
        tick();
        chk("rst_hold_cnt", fetchCount, 32'd0);
        chk("rst_hold_valid", 32'(instrValid), 32'd0);
        chk("rst_hold_instr", instrOut, 32'd0);
        chk("rst_hold_req", 32'(imemReq), 32'd0);
        decodeReady = 1'b0; reset = 1'b0;
        #1;
        chk("rst_hold_rel_req", 32'(imemReq), 32'd1);
        chk("rst_hold_rel_addr", imemAddr, RST_PC);

        chk("sb_drain", 32'(aq.size() + iq.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
